sseg_share_ctrl: RTL and testbench

- Time-shares the 4-digit seven-segment display between two requesters, e.g. the switch-decode path (req0) and a number-generator path (req1).
- Each requester presents four 7-bit active-low segment patterns.
- The block arbitrates ownership at frame boundaries with round-robin and a minimum hold time.
- It scans the digits (anode multiplexing) and uses a debounced button to lock the current owner.
- It sits between the data sources and the board's an/sseg/dp pins.

---
 rtl/sseg_share_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sseg_share_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_share_ctrl.sv
// Shares a 4-digit seven-segment display between two requesters.
// Ownership changes only at frame boundaries, using round-robin with a minimum
// hold time. A debounced button can lock the current owner. The digits are
// scanned with active-low anodes, and every output leaves a flop.
module sseg_share_ctrl #(
    parameter int REFRESH_DIV = 50000,   // clk cycles per digit slot (>= 2)
    parameter int HOLD_FRAMES = 250,     // minimum frames an owner keeps the display (>= 1)
    parameter int DEBOUNCE    = 500000   // stable samples needed to accept a button change
) (
    input  logic        clk,
    input  logic        rst,             // synchronous, active-low
    input  logic        but0,
    input  logic        req0,
    input  logic        req1,
    input  logic [27:0] data0,
    input  logic [27:0] data1,
    output logic [1:0]  gnt,
    output logic        locked,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE + 1);

    // The state encoding equals the one-hot grant, so gnt is the state register itself.
    typedef enum logic [1:0] {
        BLANK = 2'b00,
        OWN0  = 2'b01,
        OWN1  = 2'b10
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_idx, w_idx_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic              r_last, w_last_nxt;   // 1 = requester 1 was served last
    logic [27:0]       r_snap, w_snap_nxt;
    logic              r_sync1, r_sync2, r_btn, r_btn_d;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_locked, w_locked_nxt;
    logic [3:0]        r_an, w_an_nxt;
    logic [6:0]        r_sseg, w_sseg_nxt;
    logic              r_dp, w_dp_nxt;
    logic              w_fb, w_hold_expired;

    // Scan position: refresh counter, digit index and frame-boundary detection.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_idx_nxt = r_idx;
        w_fb      = 1'b0;
        if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 2'd1;
            w_fb      = (r_idx == 2'd3);
        end
    end

    // Next owner, decided only at the frame boundary.
    always_comb begin
        w_hold_inc     = (r_hold == HOLD_W'(HOLD_FRAMES)) ? r_hold : r_hold + HOLD_W'(1);
        w_hold_expired = (w_hold_inc == HOLD_W'(HOLD_FRAMES));
        w_state_nxt    = r_state;
        if (w_fb) begin
            case (r_state)
                BLANK: begin
                    if (req0 && req1) w_state_nxt = r_last ? OWN0 : OWN1;
                    else if (req0)    w_state_nxt = OWN0;
                    else if (req1)    w_state_nxt = OWN1;
                end
                OWN0: begin
                    // A requester that lets go loses the display even while locked.
                    if (!req0)                                   w_state_nxt = req1 ? OWN1 : BLANK;
                    else if (w_hold_expired && !r_locked && req1) w_state_nxt = OWN1;
                end
                OWN1: begin
                    if (!req1)                                   w_state_nxt = req0 ? OWN0 : BLANK;
                    else if (w_hold_expired && !r_locked && req0) w_state_nxt = OWN0;
                end
                default: w_state_nxt = BLANK;
            endcase
        end
    end

    // Hold count, round-robin memory and the per-frame snapshot of the owner's data.
    always_comb begin
        w_hold_nxt = r_hold;
        w_last_nxt = r_last;
        w_snap_nxt = r_snap;
        if (w_fb) begin
            if (w_state_nxt != r_state && w_state_nxt != BLANK) begin
                w_hold_nxt = '0;
                w_last_nxt = (w_state_nxt == OWN1);
            end else if (r_state != BLANK) begin
                w_hold_nxt = w_hold_inc;
            end
            // The whole frame is painted from this copy, so source updates never tear it.
            w_snap_nxt = (w_state_nxt == OWN1) ? data1 : data0;
        end
    end

    // Lock toggle and display decode for the next cycle's registered outputs.
    always_comb begin
        w_locked_nxt = r_locked ^ (r_btn & ~r_btn_d);
        w_an_nxt     = 4'hF;
        w_sseg_nxt   = 7'h7F;
        w_dp_nxt     = 1'b1;
        if (w_state_nxt != BLANK) begin
            w_an_nxt   = ~(4'b0001 << w_idx_nxt);
            w_sseg_nxt = w_snap_nxt[7*w_idx_nxt +: 7];
            w_dp_nxt   = !((w_idx_nxt == 2'd3) && w_locked_nxt);
        end
    end

    // Scan, arbitration and display registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_state  <= BLANK;
            r_hold   <= '0;
            r_last   <= 1'b1;
            r_snap   <= '1;
            r_an     <= 4'hF;
            r_sseg   <= 7'h7F;
            r_dp     <= 1'b1;
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_last   <= w_last_nxt;
            r_snap   <= w_snap_nxt;
            r_an     <= w_an_nxt;
            r_sseg   <= w_sseg_nxt;
            r_dp     <= w_dp_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    // Button synchronizer and debouncer: accept a new level after DEBOUNCE equal differing samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_btn    <= 1'b0;
            r_btn_d  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= but0;
            r_sync2 <= r_sync1;
            r_btn_d <= r_btn;
            if (r_sync2 != r_btn) begin
                if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
                    r_btn    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign gnt    = r_state;
    assign locked = r_locked;
    assign an     = r_an;
    assign sseg   = r_sseg;
    assign dp     = r_dp;

endmodule

// File: tb/tb_sseg_share_ctrl.sv
// Testbench for sseg_share_ctrl. Each row of the frame table gives the inputs
// for one 16-cycle frame and the display expected during that frame. A cycle
// position inside the frame selects the digit. The driver pushes expected
// outputs, and a negedge monitor pops and compares them.
module tb_sseg_share_ctrl;

    logic        clk;
    logic        rst;
    logic        but0;
    logic        req0;
    logic        req1;
    logic [27:0] data0;
    logic [27:0] data1;
    logic [1:0]  gnt;
    logic        locked;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    sseg_share_ctrl #(
        .REFRESH_DIV(4),
        .HOLD_FRAMES(2),
        .DEBOUNCE   (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .but0  (but0),
        .req0  (req0),
        .req1  (req1),
        .data0 (data0),
        .data1 (data1),
        .gnt   (gnt),
        .locked(locked),
        .an    (an),
        .sseg  (sseg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [27:0] d0;
        logic [27:0] d1;
        logic [27:0] d0_mid;     // data0 value from cycle mid_at onward
        int          mid_at;     // 16 = no mid-frame change
        int          press_len;  // but0 high for cycles 0..press_len-1
        logic [1:0]  gnt;        // expected grant during this frame
        logic [27:0] snap;       // expected digit patterns during this frame
        logic        lock0;      // expected locked at frame start
        int          tog_at;     // cycle from which locked is inverted; 16 = never
    } row_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
        logic [1:0] gnt;
        logic       locked;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_no = 0;

    logic [27:0] d0a, d0b, d1a;
    row_t        rows[13];
    row_t        post[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic row_t mk(input logic r0, input logic r1,
                                input logic [27:0] d0, input logic [27:0] d1,
                                input logic [27:0] d0m, input int mid_at, input int press,
                                input logic [1:0] g, input logic [27:0] snap,
                                input logic lk, input int tog);
        row_t r;
        r.r0 = r0;  r.r1 = r1;  r.d0 = d0;  r.d1 = d1;
        r.d0_mid = d0m;  r.mid_at = mid_at;  r.press_len = press;
        r.gnt = g;  r.snap = snap;  r.lock0 = lk;  r.tog_at = tog;
        return r;
    endfunction

    // Drive one frame (or its first n cycles) and queue the expected display for each cycle.
    task automatic run_frame(input row_t r, input int n);
        exp_t        e;
        logic        lk;
        int          idx;
        logic [27:0] t;
        for (int i = 0; i < n; i++) begin
            req0  = r.r0;
            req1  = r.r1;
            data1 = r.d1;
            data0 = (i >= r.mid_at) ? r.d0_mid : r.d0;
            but0  = (i < r.press_len);
            idx   = i / 4;
            lk    = (i >= r.tog_at) ? ~r.lock0 : r.lock0;
            e.gnt    = r.gnt;
            e.locked = lk;
            e.tag    = frame_no * 16 + i;
            if (r.gnt != 2'b00) begin
                e.an   = ~(4'b0001 << idx);
                t      = r.snap >> (7 * idx);
                e.sseg = t[6:0];
                e.dp   = !((idx == 3) && lk);
            end else begin
                e.an   = 4'hF;
                e.sseg = 7'h7F;
                e.dp   = 1'b1;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        frame_no++;
    endtask

    // Compare queued expectations against the outputs, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("an@%0d", e.tag),     32'(an),     32'(e.an));
            check($sformatf("sseg@%0d", e.tag),   32'(sseg),   32'(e.sseg));
            check($sformatf("dp@%0d", e.tag),     32'(dp),     32'(e.dp));
            check($sformatf("gnt@%0d", e.tag),    32'(gnt),    32'(e.gnt));
            check($sformatf("locked@%0d", e.tag), 32'(locked), 32'(e.locked));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;  but0 = 1'b0;  req0 = 1'b0;  req1 = 1'b0;
        data0 = '0;  data1 = '0;
        d0a = {7'h79, 7'h7F, 7'h7F, 7'h40};
        d0b = {7'h00, 7'h08, 7'h03, 7'h46};
        d1a = {7'h24, 7'h30, 7'h19, 7'h12};

        //            r0 r1 d0   d1   d0_mid mid press gnt    snap lk tog
        rows[0]  = mk(0, 0, '0,  '0,  '0,    16, 0,    2'b00, '0,  0, 16);
        rows[1]  = mk(0, 0, '0,  '0,  '0,    16, 0,    2'b00, '0,  0, 16);
        rows[2]  = mk(1, 1, d0a, d1a, d0a,   16, 0,    2'b00, '0,  0, 16);  // both from BLANK
        rows[3]  = mk(1, 1, d0a, d1a, d0a,   16, 0,    2'b01, d0a, 0, 16);  // last_served=1 -> req0
        rows[4]  = mk(1, 1, d0a, d1a, d0a,   16, 0,    2'b01, d0a, 0, 16);
        rows[5]  = mk(1, 1, d0a, d1a, d0a,   16, 0,    2'b10, d1a, 0, 16);  // switch at 2nd FB
        rows[6]  = mk(1, 1, d0a, d1a, d0a,   16, 0,    2'b10, d1a, 0, 16);
        rows[7]  = mk(1, 1, d0a, d1a, d0b,   4,  0,    2'b01, d0a, 0, 16);  // data0 changes in digit1
        rows[8]  = mk(1, 1, d0b, d1a, d0b,   16, 10,   2'b01, d0b, 0, 6);   // press: lock from cycle 6
        rows[9]  = mk(1, 1, d0b, d1a, d0b,   16, 0,    2'b01, d0b, 1, 16);  // hold expired, locked
        rows[10] = mk(0, 1, d0b, d1a, d0b,   16, 0,    2'b01, d0b, 1, 16);  // req0 drops, frame completes
        rows[11] = mk(0, 1, d0b, d1a, d0b,   16, 2,    2'b10, d1a, 1, 16);  // 2-cycle glitch ignored
        rows[12] = mk(0, 1, d0b, d1a, d0b,   16, 0,    2'b10, d1a, 1, 16);

        post[0]  = mk(1, 0, d0b, d1a, d0b,   16, 0,    2'b00, '0,  0, 16);  // single request from BLANK
        post[1]  = mk(0, 0, d0b, d1a, d0b,   16, 0,    2'b01, d0b, 0, 16);  // drop, nobody else -> BLANK
        post[2]  = mk(0, 1, d0b, d1a, d0b,   16, 0,    2'b00, '0,  0, 16);
        post[3]  = mk(0, 1, d0b, d1a, d0b,   16, 0,    2'b10, d1a, 0, 16);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_an",     32'(an),     32'hF);
        check("reset_sseg",   32'(sseg),   32'h7F);
        check("reset_dp",     32'(dp),     32'h1);
        check("reset_gnt",    32'(gnt),    32'h0);
        check("reset_locked", 32'(locked), 32'h0);

        for (int k = 0; k < 13; k++) run_frame(rows[k], 16);

        // Owned by requester 1 and locked; reset while digit2 is on display.
        run_frame(mk(0, 1, d0b, d1a, d0b, 16, 0, 2'b10, d1a, 1, 16), 9);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_an",     32'(an),     32'hF);
        check("midreset_sseg",   32'(sseg),   32'h7F);
        check("midreset_dp",     32'(dp),     32'h1);
        check("midreset_gnt",    32'(gnt),    32'h0);
        check("midreset_locked", 32'(locked), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < 4; k++) run_frame(post[k], 16);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
